// File: rtl/chunked_seq_adder_if.sv
// rtl/chunked_seq_adder_if.sv - operand/result handshake bundle for the chunked sequential adder
interface chunked_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_add1;
    logic [WIDTH-1:0] i_add2;
    logic             i_sub;
    logic             i_carry;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_result;
    logic             o_overflow;

    modport master (
        output i_valid, i_add1, i_add2, i_sub, i_carry, i_ready,
        input  o_ready, o_valid, o_result, o_overflow
    );

    modport slave (
        input  i_valid, i_add1, i_add2, i_sub, i_carry, i_ready,
        output o_ready, o_valid, o_result, o_overflow
    );
endinterface

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - multi-cycle add/sub that resolves CHUNK bits of the carry chain per clock
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    chunked_seq_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic [WIDTH:0]   result;
    logic             overflow;

    logic [CHUNK:0]         chunk_sum;
    logic [WIDTH+CHUNK-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_next;
    logic                   msb_carry;

    // Operands shift down so the active chunk always sits in the low bits;
    // the sum fills in from the top so it is aligned after the last chunk.
    always_comb begin
        chunk_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry};
        sum_cat   = {chunk_sum[CHUNK-1:0], sum_reg};
        sum_next  = WIDTH'(sum_cat >> CHUNK);
        msb_carry = a_reg[CHUNK-1] ^ b_reg[CHUNK-1] ^ chunk_sum[CHUNK-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        a_reg <= bus.i_add1;
                        b_reg <= bus.i_sub ? ~bus.i_add2 : bus.i_add2;
                        carry <= bus.i_sub | bus.i_carry;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_reg   <= a_reg >> CHUNK;
                    b_reg   <= b_reg >> CHUNK;
                    sum_reg <= sum_next;
                    carry   <= chunk_sum[CHUNK];
                    if (cnt == LAST) begin
                        result   <= {chunk_sum[CHUNK], sum_next};
                        overflow <= msb_carry ^ chunk_sum[CHUNK];
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.i_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ready    = (state == S_IDLE) & ~i_rst;
    assign bus.o_valid    = (state == S_DONE);
    assign bus.o_result   = result;
    assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb/tb_chunked_seq_adder.sv - scoreboard bench for chunked_seq_adder (CHUNK=4 and CHUNK=16 instances)
module tb_chunked_seq_adder;
    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    bit [17:0] sb[$];
    bit [17:0] sb2[$];

    chunked_seq_adder_if #(.WIDTH(16)) bus ();
    chunked_seq_adder_if #(.WIDTH(16)) bus2 ();

    chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) dut2 (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_op(input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic cin);
        bus.i_valid = 1'b1;
        bus.i_add1  = a;
        bus.i_add2  = b;
        bus.i_sub   = sub;
        bus.i_carry = cin;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_add1  = 'x;
        bus.i_add2  = 'x;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handoff();
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({bus.o_ready, bus.o_valid} !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_ready_valid: got %b expected 00", {bus.o_ready, bus.o_valid});
            end
        end
        vectors++;
        if ({bus.o_result, bus.o_overflow} !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_result: got %h expected 00000", {bus.o_result, bus.o_overflow});
        end
        vectors++;
        if ({bus2.o_result, bus2.o_overflow, bus2.o_valid} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_dut2: got %h expected 0", {bus2.o_result, bus2.o_overflow, bus2.o_valid});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b expected 1", bus.o_ready);
        end
    endtask

    task automatic test_basic();
        int        lat;
        bit [17:0] exp;
        sb.push_back({17'h10000, 1'b0});
        send_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_valid(lat);
        vectors++;
        if (lat != 4) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d expected 4", lat);
        end
        exp = sb.pop_front();
        vectors++;
        if ({bus.o_result, bus.o_overflow} !== exp) begin
            miscompares++;
            $display("FAIL basic_result: got %h expected %h", {bus.o_result, bus.o_overflow}, exp);
        end
        handoff();
        vectors++;
        if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_handoff: got valid/ready %b expected 01", {bus.o_valid, bus.o_ready});
        end
    endtask

    task automatic test_add_overflow();
        int        lat;
        bit [17:0] exp;
        sb.push_back({17'h08000, 1'b1});
        sb.push_back({17'h02346, 1'b0});
        for (int i = 0; i < 2; i++) begin
            if (i == 0) send_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
            else        send_op(16'h1234, 16'h1111, 1'b0, 1'b1);
            wait_valid(lat);
            vectors++;
            if (lat != 4) begin
                miscompares++;
                $display("FAIL add_latency[%0d]: got %0d expected 4", i, lat);
            end
            exp = sb.pop_front();
            vectors++;
            if ({bus.o_result, bus.o_overflow} !== exp) begin
                miscompares++;
                $display("FAIL add_result[%0d]: got %h expected %h", i, {bus.o_result, bus.o_overflow}, exp);
            end
            handoff();
        end
    endtask

    task automatic test_sub();
        int        lat;
        bit [17:0] exp;
        sb.push_back({17'h0FFFE, 1'b0});
        sb.push_back({17'h17FFF, 1'b1});
        for (int i = 0; i < 2; i++) begin
            if (i == 0) send_op(16'h0005, 16'h0007, 1'b1, 1'b0);
            else        send_op(16'h8000, 16'h0001, 1'b1, 1'b1);
            wait_valid(lat);
            exp = sb.pop_front();
            vectors++;
            if (lat != 4 || {bus.o_result, bus.o_overflow} !== exp) begin
                miscompares++;
                $display("FAIL sub_result[%0d]: got %h lat %0d expected %h lat 4",
                         i, {bus.o_result, bus.o_overflow}, lat, exp);
            end
            handoff();
        end
    endtask

    task automatic test_backpressure();
        int        lat;
        bit [17:0] exp;
        sb.push_back({17'h01000, 1'b0});
        send_op(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        bus.i_valid = 1'b1;
        bus.i_add1  = 16'hAAAA;
        bus.i_add2  = 16'h5555;
        bus.i_sub   = 1'b1;
        wait_valid(lat);
        vectors++;
        if (lat != 4) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d expected 4", lat);
        end
        exp = sb.pop_front();
        vectors++;
        if ({bus.o_result, bus.o_overflow} !== exp) begin
            miscompares++;
            $display("FAIL bp_result: got %h expected %h", {bus.o_result, bus.o_overflow}, exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus.o_valid !== 1'b1 || {bus.o_result, bus.o_overflow} !== exp) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid %b result %h expected valid 1 result %h",
                         i, bus.o_valid, {bus.o_result, bus.o_overflow}, exp);
            end
        end
        bus.i_valid = 1'b0;
        bus.i_sub   = 1'b0;
        handoff();
        vectors++;
        if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release: got valid/ready %b expected 01", {bus.o_valid, bus.o_ready});
        end
    endtask

    task automatic test_reset_abort();
        int        lat;
        bit [17:0] exp;
        bit        saw;
        send_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({bus.o_valid, bus.o_result, bus.o_overflow} !== 19'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: got %h expected 0", {bus.o_valid, bus.o_result, bus.o_overflow});
        end
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.o_valid === 1'b1) saw = 1'b1;
        end
        vectors++;
        if (saw !== 1'b0 || bus.o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_no_valid: got saw_valid %b ready %b expected 0 1", saw, bus.o_ready);
        end
        sb.push_back({17'h00002, 1'b0});
        send_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_valid(lat);
        exp = sb.pop_front();
        vectors++;
        if (lat != 4 || {bus.o_result, bus.o_overflow} !== exp) begin
            miscompares++;
            $display("FAIL abort_next_op: got %h lat %0d expected %h lat 4",
                     {bus.o_result, bus.o_overflow}, lat, exp);
        end
        handoff();
    endtask

    task automatic test_single_cycle();
        int        lat;
        bit [17:0] exp;
        sb2.push_back({17'h1FFFE, 1'b0});
        bus2.i_valid = 1'b1;
        bus2.i_add1  = 16'hFFFF;
        bus2.i_add2  = 16'hFFFF;
        bus2.i_sub   = 1'b0;
        bus2.i_carry = 1'b0;
        @(posedge clk);
        #1;
        bus2.i_valid = 1'b0;
        bus2.i_add1  = 'x;
        bus2.i_add2  = 'x;
        lat = 0;
        while (bus2.o_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat != 1) begin
            miscompares++;
            $display("FAIL single_latency: got %0d expected 1", lat);
        end
        exp = sb2.pop_front();
        vectors++;
        if ({bus2.o_result, bus2.o_overflow} !== exp) begin
            miscompares++;
            $display("FAIL single_result: got %h expected %h", {bus2.o_result, bus2.o_overflow}, exp);
        end
        bus2.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.i_ready = 1'b0;
        vectors++;
        if ({bus2.o_valid, bus2.o_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_handoff: got valid/ready %b expected 01", {bus2.o_valid, bus2.o_ready});
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_add1   = '0;
        bus.i_add2   = '0;
        bus.i_sub    = 1'b0;
        bus.i_carry  = 1'b0;
        bus.i_ready  = 1'b0;
        bus2.i_valid = 1'b0;
        bus2.i_add1  = '0;
        bus2.i_add2  = '0;
        bus2.i_sub   = 1'b0;
        bus2.i_carry = 1'b0;
        bus2.i_ready = 1'b0;

        test_reset();
        test_basic();
        test_add_overflow();
        test_sub();
        test_backpressure();
        test_reset_abort();
        test_single_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
